// File: rtl/flush_ctrl.sv
// Pipeline flush / redirect controller: decodes ID and EX control transfers into a
// per-stage squash vector and a valid/ready redirect to fetch, with a fetch-latency shadow.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no redirect outstanding; events are decoded and issued
// S_HOLD   | redirect offered but not yet accepted; IF squashed
// S_SHADOW | redirect accepted; IF squashed while fetch latency drains

module flush_ctrl #(
    parameter int XLEN      = 32,
    parameter int NSTAGE    = 2,
    parameter int ID_STAGE  = 1,
    parameter int EX_STAGE  = 2,
    parameter int FETCH_LAT = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_id_valid,
    input  logic              i_jump,
    input  logic [XLEN-1:0]   i_jump_target,
    input  logic              i_ex_valid,
    input  logic              i_bne,
    input  logic              i_jr,
    input  logic [XLEN-1:0]   i_ex_target,
    input  logic              i_redirect_ready,
    output logic              o_redirect_valid,
    output logic [XLEN-1:0]   o_redirect_pc,
    output logic [NSTAGE-1:0] o_flush,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_redirect_count
);

    localparam int SH_W = (FETCH_LAT < 2) ? 1 : $clog2(FETCH_LAT + 1);
    localparam logic [SH_W-1:0]   SH_LOAD    = SH_W'(FETCH_LAT);
    localparam logic [SH_W-1:0]   SH_ONE     = SH_W'(1);
    localparam logic [NSTAGE-1:0] EARLY_MASK = NSTAGE'((64'd1 << ID_STAGE) - 64'd1);
    localparam logic [NSTAGE-1:0] LATE_MASK  = NSTAGE'((64'd1 << EX_STAGE) - 64'd1);
    localparam logic [NSTAGE-1:0] IF_MASK    = NSTAGE'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_SHADOW = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_held_pc;
    logic [XLEN-1:0]   w_held_nxt;
    logic [SH_W-1:0]   r_sh_cnt;
    logic [SH_W-1:0]   w_sh_nxt;
    logic [CNT_W-1:0]  r_redirect_count;

    logic              w_late;
    logic              w_early;
    logic              w_new_evt;
    logic              w_valid;
    logic              w_accept;
    logic [XLEN-1:0]   w_pc;
    logic [NSTAGE-1:0] w_flush;

    // The EX instruction is older than the ID one, so a late event masks an early one.
    assign w_late  = i_ex_valid & (i_bne | i_jr);
    assign w_early = i_id_valid & i_jump & ~w_late;

    always_comb begin
        w_state_nxt = r_state;
        w_held_nxt  = r_held_pc;
        w_sh_nxt    = r_sh_cnt;
        w_new_evt   = 1'b0;
        w_valid     = 1'b0;
        w_pc        = r_held_pc;
        w_flush     = '0;

        case (r_state)
            S_IDLE: begin
                w_new_evt = w_late | w_early;
            end
            S_HOLD: begin
                w_valid = 1'b1;
                w_flush = IF_MASK;
                if (w_late) begin
                    w_flush    = LATE_MASK;
                    w_pc       = i_ex_target;
                    w_held_nxt = i_ex_target;
                end
                if (i_redirect_ready) begin
                    if (FETCH_LAT > 0) begin
                        w_state_nxt = S_SHADOW;
                        w_sh_nxt    = SH_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_SHADOW: begin
                w_flush = IF_MASK;
                if (w_late) begin
                    w_new_evt = 1'b1;
                end else begin
                    w_sh_nxt = r_sh_cnt - SH_ONE;
                    if (r_sh_cnt <= SH_ONE) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // New redirect from IDLE, or a late event cutting a shadow short.
        if (w_new_evt) begin
            w_valid = 1'b1;
            if (w_late) begin
                w_flush = LATE_MASK;
                w_pc    = i_ex_target;
            end else begin
                w_flush = EARLY_MASK;
                w_pc    = i_jump_target;
            end
            if (i_redirect_ready) begin
                if (FETCH_LAT > 0) begin
                    w_state_nxt = S_SHADOW;
                    w_sh_nxt    = SH_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end else begin
                w_held_nxt  = w_pc;
                w_state_nxt = S_HOLD;
            end
        end
    end

    assign w_accept = w_valid & i_redirect_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_held_pc        <= '0;
            r_sh_cnt         <= '0;
            r_redirect_count <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_held_pc <= w_held_nxt;
            r_sh_cnt  <= w_sh_nxt;
            if (w_accept && (r_redirect_count != CNT_MAX)) begin
                r_redirect_count <= r_redirect_count + CNT_ONE;
            end
        end
    end

    // Reset forces the squash/handshake outputs quiet even while event inputs toggle.
    assign o_redirect_valid = w_valid & ~rst;
    assign o_redirect_pc    = w_pc;
    assign o_flush          = rst ? '0 : w_flush;
    assign o_busy           = (r_state != S_IDLE) & ~rst;
    assign o_redirect_count = r_redirect_count;

endmodule

// File: tb/tb_flush_ctrl.sv
// Testbench for flush_ctrl: three parameterisations share one stimulus stream and are
// each checked every cycle against a behavioural model of the redirect rules.

module tb_flush_ctrl;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, jump, ex_valid, bne, jr, ready;
    logic [31:0] jump_target, ex_target;

    always #5 clk = ~clk;

    logic        vA, vB, vC, bA, bB, bC;
    logic [31:0] pA, pB, pC;
    logic [1:0]  fA;
    logic [3:0]  fB;
    logic [2:0]  fC;
    logic [15:0] cA;
    logic [1:0]  cB;
    logic [2:0]  cC;

    flush_ctrl #(.XLEN(32), .NSTAGE(2), .ID_STAGE(1), .EX_STAGE(2), .FETCH_LAT(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .i_id_valid(id_valid), .i_jump(jump), .i_jump_target(jump_target),
        .i_ex_valid(ex_valid), .i_bne(bne), .i_jr(jr), .i_ex_target(ex_target),
        .i_redirect_ready(ready), .o_redirect_valid(vA), .o_redirect_pc(pA), .o_flush(fA),
        .o_busy(bA), .o_redirect_count(cA));

    flush_ctrl #(.XLEN(32), .NSTAGE(4), .ID_STAGE(1), .EX_STAGE(3), .FETCH_LAT(3), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .i_id_valid(id_valid), .i_jump(jump), .i_jump_target(jump_target),
        .i_ex_valid(ex_valid), .i_bne(bne), .i_jr(jr), .i_ex_target(ex_target),
        .i_redirect_ready(ready), .o_redirect_valid(vB), .o_redirect_pc(pB), .o_flush(fB),
        .o_busy(bB), .o_redirect_count(cB));

    flush_ctrl #(.XLEN(32), .NSTAGE(3), .ID_STAGE(2), .EX_STAGE(3), .FETCH_LAT(0), .CNT_W(3)) u_c (
        .clk(clk), .rst(rst), .i_id_valid(id_valid), .i_jump(jump), .i_jump_target(jump_target),
        .i_ex_valid(ex_valid), .i_bne(bne), .i_jr(jr), .i_ex_target(ex_target),
        .i_redirect_ready(ready), .o_redirect_valid(vC), .o_redirect_pc(pC), .o_flush(fC),
        .o_busy(bC), .o_redirect_count(cC));

    logic        ob_valid [NI];
    logic        ob_busy  [NI];
    logic [31:0] ob_pc    [NI];
    logic [3:0]  ob_flush [NI];
    logic [15:0] ob_cnt   [NI];

    assign ob_valid[0] = vA;  assign ob_valid[1] = vB;  assign ob_valid[2] = vC;
    assign ob_busy[0]  = bA;  assign ob_busy[1]  = bB;  assign ob_busy[2]  = bC;
    assign ob_pc[0]    = pA;  assign ob_pc[1]    = pB;  assign ob_pc[2]    = pC;
    assign ob_flush[0] = {2'b00, fA};
    assign ob_flush[1] = fB;
    assign ob_flush[2] = {1'b0, fC};
    assign ob_cnt[0]   = cA;
    assign ob_cnt[1]   = {14'd0, cB};
    assign ob_cnt[2]   = {13'd0, cC};

    int p_id   [NI] = '{1, 1, 2};
    int p_ex   [NI] = '{2, 3, 3};
    int p_lat  [NI] = '{1, 3, 0};
    int p_cmax [NI] = '{65535, 3, 7};

    // Model: a redirect is either pending (offered, not taken) or not; after it is taken,
    // fetch stays squashed for a number of remaining shadow cycles.
    bit          m_pend [NI];
    int          m_sh   [NI];
    logic [31:0] m_held [NI];
    int          m_cnt  [NI];

    bit          e_valid [NI];
    bit          e_busy  [NI];
    bit          e_ev    [NI];
    logic [31:0] e_pc    [NI];
    logic [3:0]  e_flush [NI];

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [3:0] low_mask(input int k);
        return 4'((1 << k) - 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_pend[i] = 1'b0;
            m_sh[i]   = 0;
            m_held[i] = 32'd0;
            m_cnt[i]  = 0;
        end
    endtask

    task automatic model_outputs();
        bit late, early;
        late  = ex_valid && (bne || jr);
        early = id_valid && jump && !late;
        for (int i = 0; i < NI; i++) begin
            e_ev[i] = 1'b0;
            if (rst) begin
                e_valid[i] = 1'b0;
                e_busy[i]  = 1'b0;
                e_flush[i] = 4'd0;
                e_pc[i]    = m_held[i];
            end else begin
                e_busy[i] = m_pend[i] || (m_sh[i] > 0);
                if (m_pend[i]) begin
                    e_valid[i] = 1'b1;
                    e_pc[i]    = late ? ex_target : m_held[i];
                    e_flush[i] = late ? low_mask(p_ex[i]) : 4'd1;
                end else begin
                    e_ev[i] = late || (early && m_sh[i] == 0);
                    if (e_ev[i]) begin
                        e_valid[i] = 1'b1;
                        e_pc[i]    = late ? ex_target : jump_target;
                        e_flush[i] = late ? low_mask(p_ex[i]) : low_mask(p_id[i]);
                    end else begin
                        e_valid[i] = 1'b0;
                        e_pc[i]    = m_held[i];
                        e_flush[i] = (m_sh[i] > 0) ? 4'd1 : 4'd0;
                    end
                end
            end
        end
    endtask

    task automatic model_edge();
        bit late, acc;
        late = ex_valid && (bne || jr);
        for (int i = 0; i < NI; i++) begin
            acc = e_valid[i] && ready;
            if (acc && m_cnt[i] < p_cmax[i]) m_cnt[i]++;
            if (m_pend[i]) begin
                if (late) m_held[i] = ex_target;
                if (acc) begin
                    m_pend[i] = 1'b0;
                    m_sh[i]   = p_lat[i];
                end
            end else if (e_ev[i]) begin
                if (acc) begin
                    m_sh[i] = p_lat[i];
                end else begin
                    m_pend[i] = 1'b1;
                    m_held[i] = e_pc[i];
                    m_sh[i]   = 0;
                end
            end else if (m_sh[i] > 0) begin
                m_sh[i]--;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("valid[%0d]", i), 64'(ob_valid[i]), 64'(e_valid[i]));
            chk($sformatf("flush[%0d]", i), 64'(ob_flush[i]), 64'(e_flush[i]));
            chk($sformatf("busy[%0d]", i),  64'(ob_busy[i]),  64'(e_busy[i]));
            chk($sformatf("count[%0d]", i), 64'(ob_cnt[i]),   64'(m_cnt[i]));
            if (!rst) chk($sformatf("pc[%0d]", i), 64'(ob_pc[i]), 64'(e_pc[i]));
        end
    endtask

    task automatic step();
        #1;
        model_outputs();
        check_all();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
    endtask

    task automatic quiet(input logic rdy);
        id_valid = 1'b0; jump = 1'b0; ex_valid = 1'b0; bne = 1'b0; jr = 1'b0;
        ready = rdy;
    endtask

    task automatic idle_steps(input int n);
        quiet(1'b1);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        rst = 1'b1;
        quiet(1'b0);
        jump_target = 32'd0;
        ex_target   = 32'd0;
        model_reset();
        step();
        rst = 1'b0;
        step();

        // early jump, accepted immediately
        id_valid = 1'b1; jump = 1'b1; jump_target = 32'h40; ready = 1'b1;
        step();
        idle_steps(5);

        // simultaneous early and late: late wins
        id_valid = 1'b1; jump = 1'b1; jump_target = 32'h40;
        ex_valid = 1'b1; bne = 1'b1; ex_target = 32'h80; ready = 1'b1;
        step();
        idle_steps(5);

        // backpressure on a register jump
        quiet(1'b0);
        ex_valid = 1'b1; jr = 1'b1; ex_target = 32'h100;
        step();
        quiet(1'b0);
        step();
        step();
        ready = 1'b1;
        step();
        idle_steps(5);

        // hold, ignored early jump, then late override accepted in the same cycle
        quiet(1'b0);
        ex_valid = 1'b1; jr = 1'b1; ex_target = 32'h100;
        step();
        quiet(1'b0);
        step();
        id_valid = 1'b1; jump = 1'b1; jump_target = 32'h300;
        step();
        quiet(1'b1);
        ex_valid = 1'b1; bne = 1'b1; ex_target = 32'h200;
        step();
        idle_steps(5);

        // override without accept, then accept held value
        quiet(1'b0);
        id_valid = 1'b1; jump = 1'b1; jump_target = 32'h44;
        step();
        quiet(1'b0);
        ex_valid = 1'b1; bne = 1'b1; ex_target = 32'h204;
        step();
        quiet(1'b1);
        step();
        idle_steps(5);

        // reset asserted mid-hold
        quiet(1'b0);
        ex_valid = 1'b1; jr = 1'b1; ex_target = 32'h500;
        step();
        quiet(1'b0);
        step();
        rst = 1'b1;
        model_reset();
        ex_valid = 1'b1; jr = 1'b1; ready = 1'b1;
        step();
        rst = 1'b0;
        quiet(1'b0);
        step();

        // counter saturation on the narrow counters
        for (int k = 0; k < 9; k++) begin
            id_valid = 1'b1; jump = 1'b1; jump_target = 32'h1000 + 32'(k * 4); ready = 1'b1;
            step();
            idle_steps(4);
        end

        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            id_valid    = ($urandom_range(0, 99) < 50);
            jump        = ($urandom_range(0, 99) < 40);
            ex_valid    = ($urandom_range(0, 99) < 50);
            bne         = ($urandom_range(0, 99) < 20);
            jr          = ($urandom_range(0, 99) < 15);
            ready       = ($urandom_range(0, 99) < 55);
            jump_target = $urandom & 32'hFFFF_FFFC;
            ex_target   = $urandom & 32'hFFFF_FFFC;
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 99) < 2) begin
                rst = 1'b1;
                model_reset();
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
